// File: rtl/stack_arbiter_ctrl_pkg.sv
// Shared types and constants for the two-requester stack controller.
package stack_pkg;

  localparam int unsigned AW_DEF    = 8;
  localparam int unsigned DEPTH_DEF = 1 << AW_DEF;
  localparam int unsigned DW_DEF    = 8;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    XFER0,
    XFER1,
    RESP
  } state_t;

endpackage

// File: rtl/stack_arbiter_ctrl_if.sv
// Requester handshakes, SRAM port and occupancy status of the stack controller.
interface stack_arbiter_ctrl_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          req0, op0, wide0;
  logic [15:0]   wdata0;
  logic          done0, err0;
  logic [15:0]   rdata0;
  logic          req1, op1, wide1;
  logic [15:0]   wdata1;
  logic          done1, err1;
  logic [15:0]   rdata1;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [AW:0]   count;
  logic          full, empty;

  modport slave (
    input  req0, op0, wide0, wdata0, req1, op1, wide1, wdata1, mem_rdata,
    output done0, err0, rdata0, done1, err1, rdata1,
           mem_addr, mem_we, mem_wdata, count, full, empty
  );

  modport master (
    output req0, op0, wide0, wdata0, req1, op1, wide1, wdata1, mem_rdata,
    input  done0, err0, rdata0, done1, err1, rdata1,
           mem_addr, mem_we, mem_wdata, count, full, empty
  );
endinterface

// File: rtl/stack_arbiter_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; on a tie the side opposite last_grant wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  logic last_grant;

  always_comb begin
    gnt = '0;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset)
      last_grant <= 1'b1;
    else if (en && (|req))
      last_grant <= gnt[1];
  end
endmodule

// File: rtl/stack_arbiter_ctrl.sv
// Shares one byte-wide SRAM stack between two requesters with 8/16-bit push/pop.
module stack_arbiter_ctrl
  import stack_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic                 clk,
  input  logic                 Reset,
  stack_arbiter_ctrl_if.slave  bus
);
  state_t        state;
  logic [AW:0]   count_q;
  logic          cur, op_q, wide_q;
  logic [15:0]   wdata_q;
  logic [7:0]    hi_q;
  logic [1:0]    gnt;
  logic          sel_op, sel_wide, reject;
  logic [15:0]   sel_wdata;
  logic [AW+1:0] cnt_w, need_w;
  logic [AW-1:0] sp, sp_m1;
  logic          fire, fwho, ferr;
  logic [15:0]   fdata;

  rr_arb2 u_arb (
    .clk   (clk),
    .Reset (Reset),
    .req   ({bus.req1, bus.req0}),
    .en    (state == IDLE),
    .gnt   (gnt)
  );

  assign sel_op    = gnt[1] ? bus.op1    : bus.op0;
  assign sel_wide  = gnt[1] ? bus.wide1  : bus.wide0;
  assign sel_wdata = gnt[1] ? bus.wdata1 : bus.wdata0;

  assign cnt_w  = {1'b0, count_q};
  assign need_w = sel_wide ? (AW+2)'(2) : (AW+2)'(1);
  assign reject = (sel_op == OP_PUSH) ? (cnt_w + need_w > (AW+2)'(DEPTH))
                                      : (cnt_w < need_w);

  assign sp    = count_q[AW-1:0];
  assign sp_m1 = sp - 1'b1;

  // Both beats address through the live count, so a wide op walks sp naturally.
  assign bus.mem_addr  = (op_q == OP_POP) ? sp_m1 : sp;
  assign bus.mem_we    = ((state == XFER0) || (state == XFER1)) && (op_q == OP_PUSH) && !Reset;
  assign bus.mem_wdata = (state == XFER1) ? wdata_q[15:8] : wdata_q[7:0];

  assign bus.count = count_q;
  assign bus.full  = (count_q == (AW+1)'(DEPTH));
  assign bus.empty = (count_q == '0);

  always_comb begin
    fire  = 1'b0;
    fwho  = cur;
    ferr  = 1'b0;
    fdata = '0;
    unique case (state)
      IDLE: begin
        fwho = gnt[1];
        fire = (|gnt) && reject;
        ferr = 1'b1;
      end
      XFER0: begin
        fire = !wide_q;
        if (op_q == OP_POP) fdata = {8'h00, bus.mem_rdata[7:0]};
      end
      XFER1: begin
        fire = 1'b1;
        if (op_q == OP_POP) fdata = {hi_q, bus.mem_rdata[7:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state      <= IDLE;
      count_q    <= '0;
      cur        <= 1'b0;
      op_q       <= OP_PUSH;
      wide_q     <= 1'b0;
      wdata_q    <= '0;
      hi_q       <= '0;
      bus.done0  <= 1'b0;
      bus.done1  <= 1'b0;
      bus.err0   <= 1'b0;
      bus.err1   <= 1'b0;
      bus.rdata0 <= '0;
      bus.rdata1 <= '0;
    end else begin
      bus.done0  <= fire && !fwho;
      bus.done1  <= fire && fwho;
      bus.err0   <= fire && !fwho && ferr;
      bus.err1   <= fire && fwho && ferr;
      bus.rdata0 <= (fire && !fwho) ? fdata : '0;
      bus.rdata1 <= (fire && fwho)  ? fdata : '0;
      unique case (state)
        IDLE: begin
          if (|gnt) begin
            cur     <= gnt[1];
            op_q    <= sel_op;
            wide_q  <= sel_wide;
            wdata_q <= sel_wdata;
            state   <= reject ? RESP : XFER0;
          end
        end
        XFER0: begin
          count_q <= (op_q == OP_PUSH) ? count_q + 1'b1 : count_q - 1'b1;
          if (op_q == OP_POP) hi_q <= bus.mem_rdata[7:0];
          state <= wide_q ? XFER1 : RESP;
        end
        XFER1: begin
          count_q <= (op_q == OP_PUSH) ? count_q + 1'b1 : count_q - 1'b1;
          state   <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stack_arbiter_ctrl.sv
// Scoreboard bench for stack_arbiter_ctrl: directed ops, queued expectations, negedge monitor.
module tb_stack_arbiter_ctrl;
  import stack_pkg::*;

  logic clk = 1'b0;
  logic Reset = 1'b1;
  always #5 clk = ~clk;

  stack_arbiter_ctrl_if #(.AW(8), .DW(8)) ifc ();
  stack_arbiter_ctrl #(.DEPTH(256), .AW(8), .DW(8)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (ifc)
  );

  logic [7:0] tbmem [256];
  assign ifc.mem_rdata = tbmem[ifc.mem_addr];
  always @(posedge clk) if (ifc.mem_we) tbmem[ifc.mem_addr] <= ifc.mem_wdata;

  typedef struct { logic who; logic err; logic [15:0] rdata; int cyc; } resp_t;
  typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
  resp_t rq[$];
  wr_t   wq[$];
  resp_t mr;
  wr_t   mw;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mstk [256];
  int mcount = 0;

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (ifc.mem_we) begin
      if (wq.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", ifc.mem_addr, ifc.mem_wdata);
      end else begin
        mw = wq.pop_front();
        check("wr_addr", int'(ifc.mem_addr), int'(mw.addr));
        check("wr_data", int'(ifc.mem_wdata), int'(mw.data));
      end
    end
    if (ifc.done0 || ifc.done1) begin
      check("done_exclusive", int'(ifc.done0 && ifc.done1), 0);
      if (rq.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_done: got done0=%0b done1=%0b expected none", ifc.done0, ifc.done1);
      end else begin
        mr = rq.pop_front();
        check("resp_who", int'(ifc.done1), int'(mr.who));
        check("resp_err", int'(ifc.done1 ? ifc.err1 : ifc.err0), int'(mr.err));
        check("resp_rdata", int'(ifc.done1 ? ifc.rdata1 : ifc.rdata0), int'(mr.rdata));
        if (mr.cyc >= 0) check("resp_latency", cyc, mr.cyc);
      end
    end
  end

  task automatic predict(bit who, bit op, bit wide, logic [15:0] d, bit chk);
    resp_t r;
    wr_t w;
    int need = wide ? 2 : 1;
    int lat;
    r.who = who;
    r.rdata = '0;
    if ((op == OP_PUSH && 256 - mcount < need) || (op == OP_POP && mcount < need)) begin
      r.err = 1'b1;
      lat = 1;
    end else begin
      r.err = 1'b0;
      lat = wide ? 3 : 2;
      if (op == OP_PUSH) begin
        w.addr = 8'(mcount); w.data = d[7:0]; wq.push_back(w);
        mstk[mcount] = d[7:0]; mcount++;
        if (wide) begin
          w.addr = 8'(mcount); w.data = d[15:8]; wq.push_back(w);
          mstk[mcount] = d[15:8]; mcount++;
        end
      end else if (wide) begin
        r.rdata = {mstk[mcount-1], mstk[mcount-2]};
        mcount -= 2;
      end else begin
        r.rdata = {8'h00, mstk[mcount-1]};
        mcount--;
      end
    end
    r.cyc = chk ? cyc + lat : -1;
    rq.push_back(r);
  endtask

  task automatic drive(bit who, bit op, bit wide, logic [15:0] d);
    bit got = 1'b0;
    if (!who) begin ifc.req0 = 1'b1; ifc.op0 = op; ifc.wide0 = wide; ifc.wdata0 = d; end
    else      begin ifc.req1 = 1'b1; ifc.op1 = op; ifc.wide1 = wide; ifc.wdata1 = d; end
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      got = who ? ifc.done1 : ifc.done0;
    end
    if (!got) begin
      n_vec++; n_bad++;
      $display("FAIL done_timeout: got no done%0d expected done within 40 cycles", who);
    end else begin
      @(posedge clk); #1;
    end
    if (!who) ifc.req0 = 1'b0; else ifc.req1 = 1'b0;
  endtask

  task automatic op(bit who, bit o, bit wide, logic [15:0] d);
    predict(who, o, wide, d, 1'b1);
    drive(who, o, wide, d);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    ifc.req0 = 1'b0; ifc.req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 Reset = 1'b0;
    mcount = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t w;
    ifc.req0 = 1'b0; ifc.op0 = 1'b0; ifc.wide0 = 1'b0; ifc.wdata0 = '0;
    ifc.req1 = 1'b0; ifc.op1 = 1'b0; ifc.wide1 = 1'b0; ifc.wdata1 = '0;
    do_reset();
    check("rst_count", int'(ifc.count), 0);
    check("rst_empty", int'(ifc.empty), 1);
    check("rst_full", int'(ifc.full), 0);
    check("rst_done", int'({ifc.done0, ifc.done1, ifc.err0, ifc.err1}), 0);
    check("rst_rdata", int'(ifc.rdata0 | ifc.rdata1), 0);

    // narrow push/pop by req0
    op(0, OP_PUSH, 0, 16'h005A);
    check("cnt_after_push", int'(ifc.count), 1);
    op(0, OP_POP, 0, 16'h0000);
    check("cnt_after_pop", int'(ifc.count), 0);
    check("empty_after_pop", int'(ifc.empty), 1);

    // wide push/pop by req1
    op(1, OP_PUSH, 1, 16'h1234);
    check("cnt_after_wpush", int'(ifc.count), 2);
    op(1, OP_POP, 1, 16'h0000);
    check("cnt_after_wpop", int'(ifc.count), 0);

    // simultaneous requests from reset, then held requests alternate
    do_reset();
    predict(0, OP_PUSH, 0, 16'h00AA, 1'b0);
    predict(1, OP_PUSH, 0, 16'h00BB, 1'b0);
    fork
      drive(0, OP_PUSH, 0, 16'h00AA);
      drive(1, OP_PUSH, 0, 16'h00BB);
    join
    predict(0, OP_PUSH, 0, 16'h0001, 1'b0);
    predict(1, OP_PUSH, 0, 16'h0003, 1'b0);
    predict(0, OP_PUSH, 0, 16'h0002, 1'b0);
    predict(1, OP_PUSH, 0, 16'h0004, 1'b0);
    fork
      begin drive(0, OP_PUSH, 0, 16'h0001); drive(0, OP_PUSH, 0, 16'h0002); end
      begin drive(1, OP_PUSH, 0, 16'h0003); drive(1, OP_PUSH, 0, 16'h0004); end
    join
    check("cnt_after_alt", int'(ifc.count), 6);

    // underflow rejections
    do_reset();
    op(0, OP_POP, 0, 16'h0000);
    check("cnt_after_empty_pop", int'(ifc.count), 0);
    op(0, OP_PUSH, 0, 16'h0011);
    op(1, OP_POP, 1, 16'h0000);
    check("cnt_after_wpop_err", int'(ifc.count), 1);

    // fill to DEPTH-1, then overflow boundaries
    for (int i = 0; i < 127; i++) op(1, OP_PUSH, 1, {8'(i), 8'(i + 100)});
    check("cnt_255", int'(ifc.count), 255);
    check("not_full_255", int'(ifc.full), 0);
    op(1, OP_PUSH, 1, 16'hABCD);
    check("cnt_after_wpush_err", int'(ifc.count), 255);
    op(0, OP_PUSH, 0, 16'h00EE);
    check("cnt_256", int'(ifc.count), 256);
    check("full_256", int'(ifc.full), 1);
    op(1, OP_PUSH, 0, 16'h00FF);
    check("cnt_after_full_push", int'(ifc.count), 256);
    op(0, OP_POP, 1, 16'h0000);
    check("cnt_after_top_pop", int'(ifc.count), 254);

    // reset during the second beat of a wide push
    do_reset();
    w.addr = 8'h00; w.data = 8'hEF; wq.push_back(w);
    ifc.req1 = 1'b1; ifc.op1 = OP_PUSH; ifc.wide1 = 1'b1; ifc.wdata1 = 16'hBEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    Reset = 1'b1; ifc.req1 = 1'b0;
    @(posedge clk); #1;
    Reset = 1'b0;
    check("cnt_after_abort", int'(ifc.count), 0);
    check("empty_after_abort", int'(ifc.empty), 1);
    op(0, OP_PUSH, 0, 16'h0077);
    check("cnt_after_abort_push", int'(ifc.count), 1);

    repeat (3) @(posedge clk);
    #1;
    check("resp_queue_drained", rq.size(), 0);
    check("write_queue_drained", wq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/stack_arbiter_ctrl.md
Name: stack_arbiter_ctrl

Overview:
Controller that shares one 256x8 SRAM stack between two requesters: req0 is the CPU control unit and req1 is the interrupt unit.
- Owns the stack pointer and occupancy count.
- Performs 8-bit or 16-bit (two-beat) push/pop.
- Rejects overflow/underflow with an error response; no partial memory updates.
- Arbitrates round-robin between requesters and drives a single-port SRAM with combinational read.

Parameters:
DEPTH, 256, number of byte entries in stack memory
AW, 8, address width, DEPTH = 2**AW
DW, 8, memory data width, byte

Ports:
clk  in  1  clock, all state on rising edge
Reset  in  1  synchronous, active-high reset
req0  in  1  requester 0 request, level, held until done0
op0  in  1  requester 0 op: 0=push, 1=pop
wide0  in  1  requester 0 size: 0=8-bit, 1=16-bit
wdata0  in  16  requester 0 push data, low byte used when wide0=0
done0  out  1  one-cycle completion pulse to requester 0
err0  out  1  valid with done0: op rejected, no state change
rdata0  out  16  pop result, valid with done0; narrow pop zero-extends
req1/op1/wide1/wdata1/done1/err1/rdata1  same as requester 0, for requester 1
mem_addr  out  AW  SRAM address
mem_we  out  1  SRAM write enable, write at rising edge
mem_wdata  out  DW  SRAM write data
mem_rdata  in  DW  SRAM read data, combinational from mem_addr
count  out  AW+1  occupancy, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (sync):
  - state=IDLE, count=0.
  - done*, err*, rdata* = 0.
  - last_grant=1, so req0 wins the first tie.
  - mem_we is gated low during any cycle with Reset=1.
  - Reset mid-operation aborts it: no done pulse, and no write occurs after the reset edge.
- Stack pointer: sp = count[AW-1:0]. Push writes mem[sp] then increments. Pop reads mem[sp-1] then decrements.
- FSM states: IDLE, XFER0, XFER1, RESP.
- IDLE:
  - Grant one requester; latch op, wide and wdata.
  - Tie rule: grant the requester opposite last_grant, then update last_grant.
  - Check need = wide ? 2 : 1.
  - Push with DEPTH-count < need, or pop with count < need: go to RESP with err=1. No mem access, count unchanged.
  - Otherwise go to XFER0.
- XFER0:
  - Push: mem_we=1, mem_addr=sp, mem_wdata=wdata[7:0], count+1.
  - Pop: mem_addr=sp-1; capture mem_rdata into rdata[15:8] if wide, else rdata[7:0] with [15:8]=0; count-1.
  - Next state: wide ? XFER1 : RESP.
- XFER1:
  - Push: write wdata[15:8] at sp, count+1.
  - Pop: capture rdata[7:0], count-1.
  - Next state: RESP.
- RESP: done of the granted requester=1 for exactly one cycle, with err and rdata valid. Next state: IDLE.
- Byte order: a 16-bit push leaves the low byte deeper and the high byte on top. A 16-bit pop of the same data returns it intact. Mixed widths are legal; bytes are just bytes.
- Latency, with req sampled in IDLE at cycle N:
  - Narrow op: done at N+2.
  - Wide op: done at N+3.
  - Error: done at N+1.
- Handshake: req is level. The requester must deassert req in the cycle after done unless it issues a new op. A req high in IDLE is always a new op. Only one requester is serviced at a time; the other waits and is guaranteed the next grant.
- Output timing: mem_addr/mem_we/mem_wdata are combinational from state and latched request. mem_we=0 outside XFER states. count/full/empty are registered.
- Boundaries:
  - count never wraps.
  - A wide push at count=DEPTH-1 errors with zero writes.
  - A wide pop at count=1 errors.
  - done is never asserted to both requesters in the same cycle.

Decomposition:
- Shared package stack_pkg:
  - state enum (IDLE, XFER0, XFER1, RESP)
  - OP_PUSH=0, OP_POP=1
  - DEPTH/AW defaults
- Sub-module rr_arb2: two-input round-robin arbiter.
  - Inputs: req[1:0], last_grant.
  - Outputs: one-hot gnt, updated last_grant.
  - Combinational, plus the pointer register.

Test Plan:
- Reset, then req0 narrow push 0x5A, then narrow pop: done0 at N+2; mem[0]=0x5A; rdata0=0x005A; count 0→1→0; empty=1 at end.
- req1 wide push 0x1234: two writes, mem[0]=0x34 then mem[1]=0x12; done1 at N+3; count=2. Wide pop returns rdata1=0x1234, count=0.
- req0 and req1 both assert narrow pushes 0xAA/0xBB from reset: req0 granted first (mem[0]=0xAA), req1 next (mem[1]=0xBB). Repeat with both held: grants alternate.
- Pop on empty: done0 at N+1 with err0=1, no mem_we, count stays 0. Wide pop at count=1: err, count stays 1.
- Fill to count=255, then wide push: err1=1, mem_we never asserted, count=255. Narrow push then succeeds, full=1. A further narrow push errors.
- Assert Reset during XFER1 of a wide push: no write on the next edge; count=0; state IDLE; no done pulse. A new push afterwards lands at mem[0].
